// File: rtl/onchip_mem_stream_loader_pkg.sv
// Shared types and constants for the on-chip RAM stream loader and RAM wrapper.
package onchip_mem_stream_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
    localparam int unsigned RAM_DEPTH      = 5120;
    localparam int unsigned RAM_ADDR_W     = 13;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOP,
        PACK,
        DONE
    } loader_state_t;

    // Byte-enable mask covering lanes 0..last_lane
    function automatic logic [BYTES_PER_WORD-1:0] lanes_to_be(input logic [LANE_W-1:0] last_lane);
        lanes_to_be = {BYTES_PER_WORD{1'b1}} >> (LANE_W'(BYTES_PER_WORD - 1) - last_lane);
    endfunction

endpackage

// File: rtl/onchip_mem_byte_packer.sv
// Little-endian byte-to-word assembler: emits a word when lane 3 fills or on the last byte.
module onchip_mem_byte_packer
    import onchip_mem_stream_loader_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      beat_valid,
    input  logic [7:0]                beat_data,
    input  logic                      beat_last,
    output logic                      emit_c,
    output logic                      word_valid,
    output logic [WORD_W-1:0]         word,
    output logic [BYTES_PER_WORD-1:0] be
);

    logic [LANE_W-1:0] lane_q;
    logic [WORD_W-1:0] asm_q;
    logic [WORD_W-1:0] asm_c;

    // Merge the incoming byte into its lane and decide whether the word is complete
    always_comb begin
        asm_c                        = asm_q;
        asm_c[{lane_q, 3'b000} +: 8] = beat_data;
        emit_c = beat_valid && (beat_last || (lane_q == LANE_W'(BYTES_PER_WORD - 1)));
    end

    // Lane counter, assembly register and emitted word; word/be hold between emits
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q     <= '0;
            asm_q      <= '0;
            word_valid <= 1'b0;
            word       <= '0;
            be         <= '0;
        end else begin
            word_valid <= emit_c;
            if (emit_c) begin
                word <= asm_c;
                be   <= lanes_to_be(lane_q);
            end
            if (clear || emit_c) begin
                lane_q <= '0;
                asm_q  <= '0;
            end else if (beat_valid) begin
                lane_q <= lane_q + LANE_W'(1);
                asm_q  <= asm_c;
            end
        end
    end

endmodule

// File: rtl/onchip_mem_stream_loader.sv
// Packet byte stream to on-chip RAM loader: packs bytes into words at consecutive addresses.
module onchip_mem_stream_loader
    import onchip_mem_stream_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DEPTH  = RAM_DEPTH,
    parameter int unsigned CNT_W  = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [7:0]                in_data,
    input  logic                      in_sop,
    input  logic                      in_eop,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [BYTES_PER_WORD-1:0] mem_byteenable,
    output logic                      mem_chipselect,
    output logic                      mem_write,
    output logic [WORD_W-1:0]         mem_writedata,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          byte_count,
    output logic                      wrapped
);

    loader_state_t     state_q;
    loader_state_t     state_d;
    logic              arm_c;
    logic              take_c;
    logic              emit_c;
    logic              word_valid;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] base_c;

    // Out-of-range base addresses start at word 0
    assign base_c = (32'(base_addr) >= DEPTH) ? '0 : base_addr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; take_c marks a byte that belongs to the packet
    always_comb begin
        state_d = state_q;
        arm_c   = 1'b0;
        take_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    arm_c   = 1'b1;
                    state_d = WAIT_SOP;
                end
            end
            WAIT_SOP: begin
                if (in_valid && in_ready && in_sop) begin
                    take_c  = 1'b1;
                    state_d = in_eop ? DONE : PACK;
                end
            end
            PACK: begin
                if (in_valid && in_ready) begin
                    take_c = 1'b1;
                    if (in_eop) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags, address pointer, byte counter and registered RAM address
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ptr_q       <= '0;
            byte_count  <= '0;
            wrapped     <= 1'b0;
            mem_address <= '0;
        end else begin
            in_ready <= (state_d == WAIT_SOP) || (state_d == PACK);
            busy     <= (state_d != IDLE);
            done     <= (state_d == DONE);
            if (arm_c) begin
                ptr_q      <= base_c;
                byte_count <= '0;
                wrapped    <= 1'b0;
            end
            if (take_c) begin
                if (state_q == WAIT_SOP) begin
                    byte_count <= CNT_W'(1);
                end else if (!(&byte_count)) begin
                    byte_count <= byte_count + CNT_W'(1);
                end
            end
            if (emit_c) begin
                mem_address <= ptr_q;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    ptr_q   <= '0;
                    wrapped <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                end
            end
        end
    end

    // Word assembly; the packer's registered outputs drive the RAM write port
    onchip_mem_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (arm_c),
        .beat_valid (take_c),
        .beat_data  (in_data),
        .beat_last  (in_eop),
        .emit_c     (emit_c),
        .word_valid (word_valid),
        .word       (mem_writedata),
        .be         (mem_byteenable)
    );

    assign mem_write      = word_valid;
    assign mem_chipselect = word_valid;

endmodule
